// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state type, instruction field positions
// and the default reset PC.
package cpu_pkg;

  typedef enum logic {REQ, VALID} fetch_state_t;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM16_MSB  = 15;
  localparam int unsigned JIDX_MSB   = 25;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and instruction memory.
interface fetch_unit_if #(
  parameter int unsigned N = 32
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_rdy;
  logic [N-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_rdata
  );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jr > jump/jal > taken branch > sequential.
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]      pc_plus4,
  input  logic [JIDX_MSB:0] instr_low,
  input  logic [N-1:0]      jr_target,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic              jal,
  input  logic              jr,
  output logic [N-1:0]      next_pc,
  output logic              jr_misalign
);

  logic [N-1:0] br_offset;
  logic [N-1:0] br_target;
  logic [N-1:0] j_target;
  logic [N-1:0] jr_aligned;

  assign br_offset  = {{(N - IMM16_MSB - 3){instr_low[IMM16_MSB]}},
                       instr_low[IMM16_MSB:0], 2'b00};
  assign br_target  = pc_plus4 + br_offset;
  assign j_target   = {pc_plus4[N-1:JIDX_MSB+3], instr_low, 2'b00};
  assign jr_aligned = {jr_target[N-1:2], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_aligned;
    end else if (jump || jal) begin
      next_pc = j_target;
    end else if (branch && zero) begin
      next_pc = br_target;
    end
  end

  assign jr_misalign = jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, two-state request/valid FSM and the
// captured instruction register feeding decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned M        = 6,
  parameter logic [N-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  imem,
  output logic [N-1:0]  instr,
  output logic [M-1:0]  opcode,
  output logic [M-1:0]  funct,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          branch,
  input  logic          zero,
  input  logic          jump,
  input  logic          jal,
  input  logic          jr,
  input  logic [N-1:0]  jr_target,
  output logic [N-1:0]  pc,
  output logic [N-1:0]  pc_plus4,
  output logic          misalign
);

  fetch_state_t state;
  logic         req_q;
  logic [N-1:0] next_pc;
  logic         jr_misalign;

  assign pc_plus4       = pc + {{(N - 3){1'b0}}, 3'd4};
  assign opcode         = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct          = instr[FUNCT_MSB:FUNCT_LSB];
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  next_pc_sel #(
    .N (N)
  ) u_next_pc_sel (
    .pc_plus4    (pc_plus4),
    .instr_low   (instr[JIDX_MSB:0]),
    .jr_target   (jr_target),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jal         (jal),
    .jr          (jr),
    .next_pc     (next_pc),
    .jr_misalign (jr_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      unique case (state)
        REQ: begin
          req_q <= 1'b1;
          // A response only counts once the request is actually on the bus.
          if (req_q && imem.imem_rdy) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc          <= next_pc;
            misalign    <= jr_misalign;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected fetch addresses and
// decode values into queues; a negedge monitor pops and compares them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch, zero, jump, jal, jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  fetch_unit_if #(.N(32)) imem_bus ();

  fetch_unit #(
    .N        (32),
    .M        (6),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus.master),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jal         (jal),
    .jr          (jr),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          waits;
    int          stall;
    logic        br, z, j, jl, r;
    logic [31:0] tgt;
    logic        mis;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] p4;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] p4;
    logic [31:0] word;
    logic        mis;
  } dec_t;

  vec_t        tbl [15];
  logic [31:0] addr_q [$];
  dec_t        dec_q [$];
  int          vecs = 0;
  int          miscompares = 0;
  logic        mis_pending = 1'b0;
  logic        mis_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_bus.imem_req && n < 50) begin
      step();
      n++;
    end
    ok = imem_bus.imem_req;
    if (!ok) begin
      vecs++;
      miscompares++;
      $display("FAIL req_timeout: got imem_req=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    addr_q.push_back(v.addr);
    dec_q.push_back('{v.op, v.fn, v.p4, v.word, v.mis});
    wait_req(ok);
    if (!ok) return;
    for (int k = 0; k < v.waits; k++) begin
      check("wait_req", 32'(imem_bus.imem_req), 32'd1);
      check("wait_addr", imem_bus.imem_addr, v.addr);
      check("wait_valid", 32'(instr_valid), 32'd0);
      step();
    end
    imem_bus.imem_rdy   = 1'b1;
    imem_bus.imem_rdata = v.word;
    step();
    imem_bus.imem_rdy   = 1'b0;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    check("cap_valid", 32'(instr_valid), 32'd1);
    // Junk on memory and redirect inputs while stalled must be ignored.
    for (int k = 0; k < v.stall; k++) begin
      imem_bus.imem_rdy = 1'b1;
      jr = 1'b1; jr_target = 32'h0000_0044; branch = 1'b1; zero = 1'b1;
      check("stall_instr", instr, v.word);
      check("stall_req", 32'(imem_bus.imem_req), 32'd0);
      check("stall_pc", pc, v.addr);
      step();
    end
    imem_bus.imem_rdy = 1'b0;
    branch = v.br; zero = v.z; jump = v.j; jal = v.jl; jr = v.r; jr_target = v.tgt;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; jr_target = 32'h0;
  endtask

  // Monitor / scoreboard
  initial begin
    dec_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_bus.imem_req && imem_bus.imem_rdy) begin
          if (addr_q.size() == 0) begin
            vecs++;
            miscompares++;
            $display("FAIL fetch_addr: got unexpected fetch at %h expected none",
                     imem_bus.imem_addr);
          end else begin
            check("fetch_addr", imem_bus.imem_addr, addr_q.pop_front());
          end
        end
        check("misalign", 32'(misalign), 32'(mis_pending ? mis_exp : 1'b0));
        mis_pending = 1'b0;
        if (instr_valid && instr_ready) begin
          if (dec_q.size() == 0) begin
            vecs++;
            miscompares++;
            $display("FAIL accept: got unexpected accept of %h expected none", instr);
          end else begin
            d = dec_q.pop_front();
            check("opcode", 32'(opcode), 32'(d.op));
            check("funct", 32'(funct), 32'(d.fn));
            check("instr", instr, d.word);
            check("pc_plus4", pc_plus4, d.p4);
            check("accept_req", 32'(imem_bus.imem_req), 32'd0);
            mis_pending = 1'b1;
            mis_exp     = d.mis;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    //           addr          word          wt st br z  j  jl r  tgt           mis op     fn     p4
    tbl[0]  = '{32'h0000_0000, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_0004};
    tbl[1]  = '{32'h0000_0004, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_0008};
    tbl[2]  = '{32'h0000_0008, 32'h0000_0020, 3, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_000C};
    tbl[3]  = '{32'h0000_000C, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_0010};
    tbl[4]  = '{32'h0000_0010, 32'h1000_FFFC, 0, 0, 1, 1, 0, 0, 0, 32'h0,        0, 6'h04, 6'h3C, 32'h0000_0014};
    tbl[5]  = '{32'h0000_0004, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 1, 32'h10,       0, 6'h00, 6'h20, 32'h0000_0008};
    tbl[6]  = '{32'h0000_0010, 32'h1000_FFFC, 0, 0, 1, 0, 0, 0, 0, 32'h0,        0, 6'h04, 6'h3C, 32'h0000_0014};
    tbl[7]  = '{32'h0000_0014, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 1, 32'h1000_0000, 0, 6'h00, 6'h20, 32'h0000_0018};
    tbl[8]  = '{32'h1000_0000, 32'h0C00_0040, 0, 5, 0, 0, 0, 1, 0, 32'h0,        0, 6'h03, 6'h00, 32'h1000_0004};
    tbl[9]  = '{32'h1000_0100, 32'h0800_0040, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0203, 1, 6'h02, 6'h00, 32'h1000_0104};
    tbl[10] = '{32'h0000_0200, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 6'h00, 6'h20, 32'h0000_0204};
    tbl[11] = '{32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_0000};
    tbl[12] = '{32'h0000_0000, 32'h0000_0020, 0, 0, 1, 1, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_0004};
    tbl[13] = '{32'h0000_0000, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_0004};
    tbl[14] = '{32'h0000_0004, 32'h0000_0020, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6'h00, 6'h20, 32'h0000_0008};

    imem_bus.imem_rdy   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    instr_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; jr_target = 32'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_pc", pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_req_low", 32'(imem_bus.imem_req), 32'd0);
    step();
    check("rel_req_high", 32'(imem_bus.imem_req), 32'd1);
    check("rel_addr", imem_bus.imem_addr, 32'h0);

    for (int i = 0; i <= 12; i++) run_vec(tbl[i]);

    // Reset while a request is waiting on memory.
    wait_req(ok);
    check("midrst_addr", imem_bus.imem_addr, 32'h0000_0084);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_bus.imem_req), 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    check("midrel_req_low", 32'(imem_bus.imem_req), 32'd0);
    step();
    check("midrel_req_high", 32'(imem_bus.imem_req), 32'd1);
    check("midrel_addr", imem_bus.imem_addr, 32'h0);

    run_vec(tbl[13]);
    run_vec(tbl[14]);

    repeat (3) step();
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);
    check("dec_q_empty", 32'(dec_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
